// File: rtl/bcd_seq_converter.sv
// -----------------------------------------------------------------------------
// bcd_seq_converter
//
// Purpose:
//   Sequential binary-to-BCD converter using the shift-and-add-3 method.
//   One input bit is processed per clock. A Start/Busy/Done handshake
//   controls each conversion. The packed BCD result drives the
//   seven-segment digit displays.
//
// Parameters:
//   WIDTH  : bit width of the binary input (4..16).
//   DIGITS : number of BCD digits produced. 10**DIGITS must exceed
//            2**WIDTH - 1. This is not checked in the RTL.
//
// Ports:
//   Clock  in   1          rising-edge system clock
//   Resetn in   1          asynchronous, active-low reset
//   Start  in   1          conversion request, sampled only in IDLE
//   Bin    in   WIDTH      binary value, sampled on the accepting edge
//   Busy   out  1          high while a conversion is in progress
//   Done   out  1          one-cycle pulse when Bcd has just been updated
//   Bcd    out  4*DIGITS   packed result, digit k at [4k+3:4k], digit 0 = units
//   HEX    out  7*DIGITS   only with SEG_DECODE_EN. Active-low seven-segment
//                          decode of each Bcd digit (bit0 = a ... bit6 = g).
//
// Configuration macro:
//   SEG_DECODE_EN : when defined, adds the HEX port and the on-block decoder.
// -----------------------------------------------------------------------------
module bcd_seq_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Bin,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   Bcd
`ifdef SEG_DECODE_EN
  ,
  output logic [7*DIGITS-1:0]   HEX
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_shift;
  logic [4*DIGITS-1:0]   r_scratch;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [CW-1:0]         r_count;
  logic                  r_busy;
  logic                  r_done;

  logic [4*DIGITS-1:0]   w_adj;
  logic [4*DIGITS-1:0]   w_scratch_next;

  // Each digit is adjusted independently. A digit that is 5 or more gets +3
  // so that the following left shift carries correctly into the next digit.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5)
                                ? r_scratch[4*gi +: 4] + 4'd3
                                : r_scratch[4*gi +: 4];
    end
  endgenerate

  // Shift the adjusted scratch left by one bit. The MSB of the binary shift
  // register enters the scratch LSB. The top scratch bit falls off; it is
  // always zero when DIGITS is sized correctly.
  assign w_scratch_next = (w_adj << 1)
                        | {{(4*DIGITS-1){1'b0}}, r_shift[WIDTH-1]};

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_bcd     <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (Start) begin
            r_shift   <= Bin;
            r_scratch <= '0;
            r_count   <= CW'(WIDTH);
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scratch <= w_scratch_next;
          r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
          r_count   <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            // Last bit: publish the whole result in one step so that Bcd is
            // never seen partially updated.
            r_bcd   <= w_scratch_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;
  assign Bcd  = r_bcd;

`ifdef SEG_DECODE_EN
  // Active-low segments: bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // HEX decodes the Bcd register directly. It therefore changes only when
  // DONE is entered or on reset.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
      assign HEX[7*gi +: 7] = seg7(r_bcd[4*gi +: 4]);
    end
  endgenerate
`else
  // No on-block decoder. External display decoders consume Bcd.
`endif

endmodule

// File: tb/tb_bcd_seq_converter.sv
// -----------------------------------------------------------------------------
// tb_bcd_seq_converter
//
// Purpose:
//   Self-checking bench for bcd_seq_converter with WIDTH=8 and DIGITS=3.
//
// Structure:
//   - A table of {Bin, expected Bcd} records drives single requests.
//   - Hand-written sequences cover held Start, ignored Start pulses and an
//     asynchronous reset in the middle of a conversion.
//   - Expected results go into a queue when a request is driven. They are
//     popped and compared when Done is seen.
//
// Ports: none (top-level bench).
// Macro: SEG_DECODE_EN adds checks on the HEX output.
// -----------------------------------------------------------------------------
module tb_bcd_seq_converter;

  localparam int W = 8;
  localparam int D = 3;

  logic            Clock  = 1'b0;
  logic            Resetn = 1'b0;
  logic            Start  = 1'b0;
  logic [W-1:0]    Bin    = '0;
  logic            Busy;
  logic            Done;
  logic [4*D-1:0]  Bcd;
`ifdef SEG_DECODE_EN
  logic [7*D-1:0]  HEX;
`endif

  always #5 Clock = ~Clock;

  bcd_seq_converter #(.WIDTH(W), .DIGITS(D)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Start  (Start),
    .Bin    (Bin),
    .Busy   (Busy),
    .Done   (Done),
    .Bcd    (Bcd)
`ifdef SEG_DECODE_EN
    ,
    .HEX    (HEX)
`endif
  );

  typedef struct {
    logic [W-1:0]   bin;
    logic [4*D-1:0] exp;
  } vec_t;

  vec_t            vecs[10];
  logic [4*D-1:0]  sb[$];
  logic [4*D-1:0]  prev_bcd;
  int              tests    = 0;
  int              fails    = 0;
  int              done_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Decimal reference built from division. It is independent of the
  // shift-and-add-3 algorithm.
  function automatic logic [4*D-1:0] ref_bcd(input int v);
    logic [4*D-1:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // Monitor: pops the scoreboard on each Done. Outside Done cycles it checks
  // that Bcd has not changed; reset cycles are excluded from that check.
  initial begin
    logic [4*D-1:0] e;
    prev_bcd = '0;
    forever begin
      @(negedge Clock);
      if (Resetn) begin
        if (Done) begin
          done_cnt++;
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("bcd_result", int'(Bcd), int'(e));
            $display("[TB] result Bcd=0x%03h expected 0x%03h", Bcd, e);
          end
        end else begin
          check("bcd_stable", int'(Bcd), int'(prev_bcd));
        end
      end
      prev_bcd = Bcd;
    end
  end

  // One request with full latency checks: Busy in cycles 1..W, a Done pulse
  // in cycle W+1, and exactly one Done per request.
  task automatic convert(input logic [W-1:0] b, input logic [4*D-1:0] e);
    int d0;
    @(negedge Clock);
    Start = 1'b1;
    Bin   = b;
    sb.push_back(e);
    d0 = done_cnt;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    Bin   = W'($urandom);
    for (int c = 1; c <= W; c++) begin
      @(negedge Clock);
      check("busy_during_shift", int'(Busy), 1);
      check("no_done_during_shift", int'(Done), 0);
    end
    @(negedge Clock);
    check("done_pulse", int'(Done), 1);
    check("busy_low_in_done", int'(Busy), 0);
    @(negedge Clock);
    check("done_one_cycle", int'(Done), 0);
    check("one_done_per_request", done_cnt - d0, 1);
    $display("[TB] convert Bin=%0d -> expected 0x%03h", b, e);
  endtask

  initial begin
    int d0;
    logic [W-1:0] v;

    vecs[0] = '{8'd255, 12'h255};
    vecs[1] = '{8'd0,   12'h000};
    vecs[2] = '{8'd99,  12'h099};
    vecs[3] = '{8'd100, 12'h100};
    vecs[4] = '{8'd1,   12'h001};
    vecs[5] = '{8'd10,  12'h010};
    vecs[6] = '{8'd128, 12'h128};
    vecs[7] = '{8'd59,  12'h059};
    vecs[8] = '{8'd200, 12'h200};
    vecs[9] = '{8'd199, 12'h199};

    // Reset state
    #12;
    check("reset_busy", int'(Busy), 0);
    check("reset_done", int'(Done), 0);
    check("reset_bcd", int'(Bcd), 0);
`ifdef SEG_DECODE_EN
    for (int k = 0; k < D; k++) check("reset_hex", int'(HEX[7*k +: 7]), 7'b1000000);
`endif
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);

    // Table-driven single requests
    for (int i = 0; i < 10; i++) convert(vecs[i].bin, vecs[i].exp);

    // Seven-segment decode of 255
    convert(8'd255, 12'h255);
`ifdef SEG_DECODE_EN
    check("hex_digit2", int'(HEX[20:14]), 7'b0100100);
    check("hex_digit1", int'(HEX[13:7]),  7'b0010010);
    check("hex_digit0", int'(HEX[6:0]),   7'b0010010);
`endif

    // Start held high for 30 cycles with Bin changing every cycle.
    // A new conversion should be accepted every W+2 = 10 cycles.
    d0 = done_cnt;
    for (int n = 0; n < 30; n++) begin
      @(negedge Clock);
      v     = W'($urandom);
      Start = 1'b1;
      Bin   = v;
      if (n % 10 == 0) sb.push_back(ref_bcd(int'(v)));
    end
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    check("held_start_done_count", done_cnt - d0, 3);
    check("held_start_idle", int'(Busy), 0);
    check("held_start_sb_empty", sb.size(), 0);
    $display("[TB] held-start sequence: %0d conversions", done_cnt - d0);

    // Start pulses during SHIFT and during DONE are ignored
    d0 = done_cnt;
    @(negedge Clock);
    Start = 1'b1;
    Bin   = 8'd77;
    sb.push_back(12'h077);
    @(posedge Clock);
    #1;
    Start = 1'b0;
    Bin   = 8'd88;
    repeat (3) @(negedge Clock);
    Start = 1'b1;
    Bin   = 8'd33;
    @(negedge Clock);
    Start = 1'b0;
    repeat (5) @(negedge Clock);
    check("ignore_done_cycle", int'(Done), 1);
    Start = 1'b1;
    Bin   = 8'd44;
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    check("ignore_start_done_count", done_cnt - d0, 1);
    check("ignore_start_idle", int'(Busy), 0);
    $display("[TB] ignored-start sequence: %0d conversion", done_cnt - d0);

    // Asynchronous reset in cycle 4 of a Bin=200 conversion
    @(negedge Clock);
    Start = 1'b1;
    Bin   = 8'd200;
    sb.push_back(12'h200);
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    #2;
    Resetn = 1'b0;
    sb.delete();
    #1;
    check("midreset_busy", int'(Busy), 0);
    check("midreset_done", int'(Done), 0);
    check("midreset_bcd", int'(Bcd), 0);
`ifdef SEG_DECODE_EN
    for (int k = 0; k < D; k++) check("midreset_hex", int'(HEX[7*k +: 7]), 7'b1000000);
`endif
    d0 = done_cnt;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    repeat (12) @(negedge Clock);
    check("midreset_no_done", done_cnt - d0, 0);
    check("midreset_idle", int'(Busy), 0);
    $display("[TB] mid-conversion reset: Bcd=0x%03h", Bcd);
    convert(8'd200, 12'h200);

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
